// File: rtl/wfq_event_arbiter_pkg.sv
// Shared types and defaults for the WFQ event arbiter.
// Covers FSM state and grant encodings plus parameter defaults.
package wfq_event_arbiter_pkg;

  localparam int FW_DEF    = 13;
  localparam int GAP_DEF   = 4;
  localparam int CNT_W_DEF = 16;
  localparam int TMR_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_ARR = 1'b0,
    GRANT_DEP = 1'b1
  } grant_t;

endpackage

// File: rtl/wfq_event_arbiter_if.sv
// Requester, sum_weight and status signals of the event arbiter.
// master = requester/consumer side, slave = arbiter side.
interface wfq_event_arbiter_if
  import wfq_event_arbiter_pkg::*;
#(
  parameter int FW    = FW_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             arr_req;
  logic [FW-1:0]    arr_flow_id;
  logic             arr_ack;
  logic             dep_req;
  logic [FW-1:0]    dep_flow_id;
  logic             dep_ack;
  logic             arrival;
  logic             depart;
  logic [FW-1:0]    flow_id;
  logic [CNT_W-1:0] pkt_cnt;
  logic             err_underflow;
  logic             busy;

  modport master (
    output arr_req, arr_flow_id, dep_req, dep_flow_id,
    input  arr_ack, dep_ack, arrival, depart, flow_id,
    input  pkt_cnt, err_underflow, busy
  );

  modport slave (
    input  arr_req, arr_flow_id, dep_req, dep_flow_id,
    output arr_ack, dep_ack, arrival, depart, flow_id,
    output pkt_cnt, err_underflow, busy
  );

endinterface

// File: rtl/wfq_event_arbiter_gap_timer.sv
// Spacing timer: loads a count, decrements to zero, flags done.
// done is high whenever the count has reached zero.
module wfq_event_arbiter_gap_timer
  import wfq_event_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  // Reload on each issue, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/wfq_event_arbiter.sv
// Arbitrates arrival/departure events into sum_weight with
// alternating priority, event spacing and a queued-packet count.
module wfq_event_arbiter
  import wfq_event_arbiter_pkg::*;
#(
  parameter int FW    = FW_DEF,
  parameter int GAP   = GAP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  wfq_event_arbiter_if.slave bus
);

  localparam logic [TMR_W-1:0] GAP_LD =
    TMR_W'((GAP > 1) ? GAP - 2 : 0);

  state_t state, state_nxt;
  grant_t grant, grant_nxt, last_grant, lg_d;

  logic cnt_full, cnt_zero;
  logic arr_ok, dep_ok;
  logic pick_arr, pick_dep;
  logic reject, tmr_done;

  logic             arr_ack_d, dep_ack_d;
  logic             depart_d, err_d;
  logic [FW-1:0]    flow_d;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_full = &bus.pkt_cnt;
  assign cnt_zero = (bus.pkt_cnt == '0);
  assign arr_ok   = bus.arr_req && !cnt_full;
  assign dep_ok   = bus.dep_req;
  assign reject   = (state == ST_ISSUE) &&
                    (grant == GRANT_DEP) && cnt_zero;

  // Tie goes to whichever side was not granted last.
  assign pick_arr = arr_ok &&
                    (!dep_ok || last_grant == GRANT_DEP);
  assign pick_dep = dep_ok &&
                    (!arr_ok || last_grant == GRANT_ARR);

  wfq_event_arbiter_gap_timer u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .load_val (GAP_LD),
    .done     (tmr_done)
  );

  // State, grant and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      grant             <= GRANT_ARR;
      last_grant        <= GRANT_DEP;
      bus.arr_ack       <= 1'b0;
      bus.dep_ack       <= 1'b0;
      bus.arrival       <= 1'b0;
      bus.depart        <= 1'b0;
      bus.err_underflow <= 1'b0;
      bus.flow_id       <= '0;
      bus.pkt_cnt       <= '0;
      bus.busy          <= 1'b0;
    end else begin
      state             <= state_nxt;
      grant             <= grant_nxt;
      last_grant        <= lg_d;
      bus.arr_ack       <= arr_ack_d;
      bus.dep_ack       <= dep_ack_d;
      bus.arrival       <= arr_ack_d;
      bus.depart        <= depart_d;
      bus.err_underflow <= err_d;
      bus.flow_id       <= flow_d;
      bus.pkt_cnt       <= cnt_d;
      bus.busy          <= (state_nxt != ST_IDLE);
    end
  end

  // Next state; the last gap cycle arbitrates like IDLE
  // so events land exactly GAP cycles apart.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    unique case (state)
      ST_ISSUE: begin
        if (reject || GAP == 1) state_nxt = ST_IDLE;
        else                    state_nxt = ST_GAP;
      end
      ST_IDLE, ST_GAP: begin
        if (state == ST_IDLE || tmr_done) begin
          state_nxt = ST_IDLE;
          if (pick_arr) begin
            state_nxt = ST_ISSUE;
            grant_nxt = GRANT_ARR;
          end else if (pick_dep) begin
            state_nxt = ST_ISSUE;
            grant_nxt = GRANT_DEP;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Issue-cycle outputs, counter update and priority record.
  always_comb begin
    arr_ack_d = (state == ST_ISSUE) && (grant == GRANT_ARR);
    dep_ack_d = (state == ST_ISSUE) && (grant == GRANT_DEP);
    depart_d  = dep_ack_d && !cnt_zero;
    err_d     = dep_ack_d && cnt_zero;
    flow_d    = bus.flow_id;
    cnt_d     = bus.pkt_cnt;
    lg_d      = last_grant;
    if (state == ST_ISSUE) lg_d = grant;
    if (arr_ack_d) begin
      flow_d = bus.arr_flow_id;
      cnt_d  = bus.pkt_cnt + CNT_W'(1);
    end else if (depart_d) begin
      flow_d = bus.dep_flow_id;
      cnt_d  = bus.pkt_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wfq_event_arbiter.sv
// Directed bench for wfq_event_arbiter: a GAP=4/16-bit build
// and a GAP=1/4-bit build for back-to-back and full-counter cases.
module tb_wfq_event_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wfq_event_arbiter_if #(.FW(13), .CNT_W(16)) if_a ();
  wfq_event_arbiter_if #(.FW(13), .CNT_W(4))  if_b ();

  wfq_event_arbiter #(.FW(13), .GAP(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  wfq_event_arbiter #(.FW(13), .GAP(1), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_arr(input logic [12:0] f);
    int n;
    if_a.arr_flow_id = f;
    if_a.arr_req = 1'b1;
    n = 0;
    do begin tick(); n++; end
    while (!if_a.arr_ack && n < 20);
    chk("a_arr_ack", if_a.arr_ack, 1);
    if_a.arr_req = 1'b0;
  endtask

  task automatic a_dep(input logic [12:0] f);
    int n;
    if_a.dep_flow_id = f;
    if_a.dep_req = 1'b1;
    n = 0;
    do begin tick(); n++; end
    while (!if_a.dep_ack && n < 20);
    chk("a_dep_ack", if_a.dep_ack, 1);
    if_a.dep_req = 1'b0;
  endtask

  task automatic a_idle();
    int n;
    n = 0;
    while (if_a.busy && n < 20) begin tick(); n++; end
    chk("a_idle", if_a.busy, 0);
  endtask

  // Mutual exclusion of events and acks on every cycle.
  always @(negedge clk) begin
    chk("a_ev_excl", if_a.arrival & if_a.depart, 0);
    chk("a_ack_excl", if_a.arr_ack & if_a.dep_ack, 0);
    chk("b_ev_excl", if_b.arrival & if_b.depart, 0);
  end

  initial begin
    int n, ev, cyc, last_t, acks;
    if_a.arr_req = 0; if_a.dep_req = 0;
    if_a.arr_flow_id = '0; if_a.dep_flow_id = '0;
    if_b.arr_req = 0; if_b.dep_req = 0;
    if_b.arr_flow_id = '0; if_b.dep_flow_id = '0;

    tick(); tick();
    chk("rst_arr_ack", if_a.arr_ack, 0);
    chk("rst_arrival", if_a.arrival, 0);
    chk("rst_pkt_cnt", if_a.pkt_cnt, 0);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_flow", if_a.flow_id, 0);
    rst = 1'b0;

    // Single arrival, flow 5.
    if_a.arr_flow_id = 13'd5;
    if_a.arr_req = 1'b1;
    tick();
    chk("t1_busy0", if_a.busy, 1);
    chk("t1_early", if_a.arrival, 0);
    tick();
    chk("t1_ack", if_a.arr_ack, 1);
    chk("t1_arrival", if_a.arrival, 1);
    chk("t1_flow", if_a.flow_id, 5);
    chk("t1_cnt", if_a.pkt_cnt, 1);
    chk("t1_busy1", if_a.busy, 1);
    if_a.arr_req = 1'b0;
    tick(); chk("t1_busy2", if_a.busy, 1);
    chk("t1_pulse", if_a.arr_ack, 0);
    tick(); chk("t1_busy3", if_a.busy, 1);
    tick(); chk("t1_busy_end", if_a.busy, 0);

    // Build pkt_cnt=3 with last grant = departure.
    a_arr(13'd6); a_arr(13'd7); a_arr(13'd8);
    a_dep(13'd15);
    a_idle();
    chk("t2_cnt_pre", if_a.pkt_cnt, 3);

    // Both held: ARR,DEP,ARR,DEP exactly 4 cycles apart.
    if_a.arr_flow_id = 13'd10;
    if_a.dep_flow_id = 13'd20;
    if_a.arr_req = 1'b1;
    if_a.dep_req = 1'b1;
    ev = 0; cyc = 0; last_t = 0;
    while (ev < 4 && cyc < 40) begin
      tick(); cyc++;
      if (if_a.arrival || if_a.depart) begin
        chk("t2_kind", if_a.arrival, (ev % 2 == 0) ? 1 : 0);
        chk("t2_flow", if_a.flow_id, (ev % 2 == 0) ? 10 : 20);
        if (ev > 0) chk("t2_space", cyc - last_t, 4);
        last_t = cyc;
        ev++;
      end
    end
    chk("t2_events", ev, 4);
    chk("t2_cnt", if_a.pkt_cnt, 3);
    if_a.arr_req = 1'b0;
    if_a.dep_req = 1'b0;

    // Drain to zero, then an impossible departure.
    a_dep(13'd21); a_dep(13'd21); a_dep(13'd21);
    a_idle();
    chk("t3_cnt_pre", if_a.pkt_cnt, 0);
    if_a.dep_flow_id = 13'd9;
    if_a.dep_req = 1'b1;
    tick();
    chk("t3_busy", if_a.busy, 1);
    if_a.arr_flow_id = 13'd11;
    if_a.arr_req = 1'b1;
    tick();
    chk("t3_dep_ack", if_a.dep_ack, 1);
    chk("t3_err", if_a.err_underflow, 1);
    chk("t3_depart", if_a.depart, 0);
    chk("t3_cnt", if_a.pkt_cnt, 0);
    chk("t3_flow_hold", if_a.flow_id, 21);
    chk("t3_no_gap", if_a.busy, 0);
    if_a.dep_req = 1'b0;
    tick();
    chk("t3_err_pulse", if_a.err_underflow, 0);
    chk("t3_arr_wait", if_a.arr_ack, 0);
    tick();
    chk("t3_arr_ack", if_a.arr_ack, 1);
    chk("t3_arr_flow", if_a.flow_id, 11);
    chk("t3_arr_cnt", if_a.pkt_cnt, 1);
    if_a.arr_req = 1'b0;

    // Reset while in GAP with a request held.
    a_idle();
    if_a.arr_flow_id = 13'd12;
    if_a.arr_req = 1'b1;
    n = 0;
    do begin tick(); n++; end
    while (!if_a.arr_ack && n < 20);
    chk("t4_ack", if_a.arr_ack, 1);
    chk("t4_cnt_pre", if_a.pkt_cnt, 2);
    tick();
    chk("t4_in_gap", if_a.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_busy", if_a.busy, 0);
    chk("t4_rst_cnt", if_a.pkt_cnt, 0);
    chk("t4_rst_flow", if_a.flow_id, 0);
    chk("t4_rst_ack", if_a.arr_ack, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t4_wait", if_a.arr_ack, 0);
    tick();
    chk("t4_reissue", if_a.arr_ack, 1);
    chk("t4_cnt", if_a.pkt_cnt, 1);
    chk("t4_flow", if_a.flow_id, 12);
    if_a.arr_req = 1'b0;

    // GAP=1: back-to-back arrivals every 2 cycles.
    if_b.arr_flow_id = 13'd100;
    if_b.arr_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      n = 0;
      do begin tick(); n++; end
      while (!if_b.arr_ack && n < 10);
      chk("b2b_ack", if_b.arr_ack, 1);
      chk("b2b_arrival", if_b.arrival, 1);
      chk("b2b_space", n, 2);
      chk("b2b_flow", if_b.flow_id, 100 + i);
      if (if_b.arr_ack) acks++;
      if (i == 9) chk("b2b_cnt10", if_b.pkt_cnt, 10);
      if_b.arr_flow_id = 13'(101 + i);
    end
    chk("b2b_acks", acks, 15);
    chk("full_cnt", if_b.pkt_cnt, 4'hF);

    // Full counter stalls the arrival without an ack.
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_b.arr_ack) acks++;
    end
    chk("full_stall", acks, 0);
    chk("full_busy", if_b.busy, 0);
    chk("full_hold", if_b.pkt_cnt, 4'hF);
    if_b.dep_flow_id = 13'd40;
    if_b.dep_req = 1'b1;
    n = 0;
    do begin tick(); n++; end
    while (!if_b.dep_ack && n < 10);
    chk("full_dep_ack", if_b.dep_ack, 1);
    chk("full_depart", if_b.depart, 1);
    chk("full_dep_cnt", if_b.pkt_cnt, 4'hE);
    chk("full_dep_flow", if_b.flow_id, 40);
    if_b.dep_req = 1'b0;
    n = 0;
    do begin tick(); n++; end
    while (!if_b.arr_ack && n < 10);
    chk("full_arr_ack", if_b.arr_ack, 1);
    chk("full_arr_lat", n, 2);
    chk("full_arr_cnt", if_b.pkt_cnt, 4'hF);
    chk("full_arr_flow", if_b.flow_id, 115);
    if_b.arr_req = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
